dmem_responder: RTL
===================

# dmem_responder

Data-memory responder for the MIPS datapath: the slave end of the datapath's load/store port. It accepts one request at a time over a valid/ready handshake, waits a programmable latency, performs the byte/half/word access on an internal little-endian RAM, and returns a response over a second valid/ready handshake. It replaces the zero-latency combinational data RAM so the pipeline's stall logic can be exercised against realistic memory timing.

## Interface
- ADDR_WIDTH, 10, word-address bits; RAM holds 2^ADDR_WIDTH 32-bit words (byte range 0 .. 4*2^ADDR_WIDTH-1).
- LATENCY, 2, edges from request acceptance to response valid; legal range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset; one clock, reset is asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  response present.
- resp_ready  in  1  datapath accepts the response.
- resp_rdata  out  32  load data, right-aligned, zero-extended; 0 for stores and errors.
- resp_err  out  1  request was misaligned, out of range, or illegal size.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, capture we/size/addr/wdata, load counter with LATENCY-1, go to WAIT.
- WAIT: req_ready=0. Counter nonzero -> decrement. Counter zero -> execute access, go to RESP.
- Execute: error check first. Error if size==3; size==1 with addr[0]=1; size==2 with addr[1:0]!=0; addr >= 4*2^ADDR_WIDTH (any upper bit set). On error: no RAM write, resp_err=1, resp_rdata=0.
- Store: byte lane = addr[1:0]; byte writes lane addr[1:0] with wdata[7:0]; half writes lanes addr[1]*2 and +1 with wdata[15:0]; word writes all lanes. Other lanes untouched.
- Load: word read at addr[ADDR_WIDTH+1:2], shifted right by 8*addr[1:0], masked to size, zero-extended. Sign extension belongs to the datapath.
- RESP: resp_valid=1, resp_rdata/resp_err held stable. On resp_ready -> IDLE.
- One outstanding request; no request accepted in WAIT or RESP.
- RAM has no reset; contents are undefined until written.

## Timing
- Reset (rstn low, asynchronously): state=IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, counter=0. req_ready goes to 1 at the first rising edge with rstn high.
- Acceptance at edge E0 -> resp_valid rises after edge E_LATENCY. Store is committed to RAM at that same edge.
- Response consumed at edge Ec (resp_valid&&resp_ready) -> req_ready=1 after Ec. Next acceptance is at Ec+1 or later. Minimum period per access: LATENCY+2 edges.
- Response backpressure: resp_ready low holds RESP indefinitely. Outputs do not change.
- req_valid dropped while req_ready=0: ignored; request fields are sampled only at acceptance.
- Reset during WAIT: pending store is discarded, RAM unchanged. Reset during RESP: response is lost, RAM keeps the committed store.
- Load after store to the same address: returns the stored data, because the store committed before the later acceptance.

## Test plan
- Reset then idle: rstn low 2 cycles -> all outputs 0. After release: req_ready=1 at next edge, resp_valid stays 0.
- Word store/load, LATENCY=2: sw 0xDEADBEEF @0x10 -> resp_valid 2 edges after acceptance, rdata=0, err=0. lw @0x10 -> rdata=0xDEADBEEF.
- Sub-word loads after the above:
  - lb @0x11 -> 0x000000BE
  - lh @0x12 -> 0x0000DEAD
- Sub-word store: sb 0x00000055 @0x13, then lw @0x10 -> 0x55ADBEEF. Then sh 0x1234 @0x10, lw @0x10 -> 0x55AD1234.
- Errors, each -> err=1, rdata=0:
  - lw @0x12
  - sh @0x11
  - size=3 @0x0
  - sw @0x1000 with ADDR_WIDTH=10
  - Follow-up lw @0x10 -> RAM unchanged.
- Backpressure and reset:
  - Hold resp_ready=0 for 5 cycles during a load -> resp_valid and rdata stable throughout.
  - sw 0xCAFEF00D @0x20 with rstn pulsed low one edge after acceptance (LATENCY=4) -> outputs 0 immediately. A later lw @0x20 returns the prior contents.

Source files
------------

// File: rtl/dmem_responder.sv
// Latency-programmable data-memory slave for the MIPS load/store port.
// One request in flight; byte/half/word access on a little-endian RAM built from byte lanes.

module dmem_lane #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  assign rdata = mem[addr];
endmodule

module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic                          exec;
  logic                          err;
  logic [NUM_LANES-1:0]          be;
  logic [NUM_LANES-1:0][7:0]     wr_lanes;
  logic [NUM_LANES-1:0][7:0]     rd_lanes;
  logic [31:0]                   rd_word;
  logic [31:0]                   rd_shift;
  logic [31:0]                   ld_data;

  assign exec = (state == WAIT) && (cnt == 4'd0);

  always_comb begin
    err = 1'b0;
    case (size_q)
      2'd0:    err = 1'b0;
      2'd1:    err = addr_q[0];
      2'd2:    err = |addr_q[1:0];
      default: err = 1'b1;
    endcase
    // Anything above the RAM's byte range is out of bounds.
    if (|(addr_q >> (ADDR_WIDTH + 2))) err = 1'b1;
  end

  always_comb begin
    be       = 4'b0000;
    wr_lanes = wdata_q;
    case (size_q)
      2'd0: begin
        be       = 4'b0001 << addr_q[1:0];
        wr_lanes = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wdata_q[15:0]}};
      end
      2'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    dmem_lane #(.AW(ADDR_WIDTH)) u_lane (
      .clk   (clk),
      .we    (exec && !err && we_q && be[i]),
      .addr  (addr_q[ADDR_WIDTH+1:2]),
      .wdata (wr_lanes[i]),
      .rdata (rd_lanes[i])
    );
  end

  assign rd_word  = rd_lanes;
  assign rd_shift = rd_word >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (size_q)
      2'd0:    ld_data = {24'h0, rd_shift[7:0]};
      2'd1:    ld_data = {16'h0, rd_shift[15:0]};
      default: ld_data = rd_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            size_q    <= req_size;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            cnt       <= 4'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            resp_valid <= 1'b1;
            resp_err   <= err;
            resp_rdata <= (err || we_q) ? 32'h0 : ld_data;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
